// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot to binary stream encoder.
// Flag bundle travels with each beat; bin_width picks the index width.
package onehot_pkg;

    typedef struct packed {
        logic zero;
        logic multi;
    } oh_flags_t;

    // A one-bit vector still needs a one-bit index port.
    function automatic int bin_width(input int onehot_width);
        return (onehot_width == 1) ? 1 : $clog2(onehot_width);
    endfunction

endpackage

// File: rtl/onehot_enc_prio.sv
// Combinational one-hot to binary encoder with zero and multi-hot detection.
// For multi-hot input, PRIO_MSB selects whether the lowest or the highest set index wins.
module onehot_enc_prio
    import onehot_pkg::*;
#(
    parameter int ONEHOT_WIDTH = 16,
    parameter bit PRIO_MSB     = 1'b0,
    localparam int BIN_WIDTH   = bin_width(ONEHOT_WIDTH)
) (
    input  logic [ONEHOT_WIDTH-1:0] onehot_i,
    output logic [BIN_WIDTH-1:0]    bin_o,
    output oh_flags_t               flags_o
);

    logic [BIN_WIDTH-1:0] bin_s;
    logic                 found_s;

    // With PRIO_MSB the scan keeps overwriting, so the last (highest) set bit wins.
    always_comb begin
        bin_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (onehot_i[i] && (PRIO_MSB || !found_s)) begin
                bin_s   = BIN_WIDTH'(i);
                found_s = 1'b1;
            end else begin
                bin_s   = bin_s;
            end
        end
    end

    assign bin_o         = bin_s;
    assign flags_o.zero  = (onehot_i == '0);
    assign flags_o.multi = ((onehot_i & (onehot_i - ONEHOT_WIDTH'(1))) != '0);

endmodule

// File: rtl/onehot_to_bin_stream.sv
// Handshaked one-hot to binary encoder: one output register, flush, and a
// saturating count of accepted zero/multi-hot beats.
module onehot_to_bin_stream
    import onehot_pkg::*;
#(
    parameter int ONEHOT_WIDTH  = 16,
    parameter bit PRIO_MSB      = 1'b0,
    parameter bit DROP_INVALID  = 1'b0,
    parameter int ERR_CNT_WIDTH = 8,
    localparam int BIN_WIDTH    = bin_width(ONEHOT_WIDTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [ONEHOT_WIDTH-1:0]  onehot_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [BIN_WIDTH-1:0]     bin_o,
    output logic                     zero_o,
    output logic                     multi_o,
    input  logic                     err_clr_i,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);

    logic [BIN_WIDTH-1:0]     enc_bin_s;
    oh_flags_t                enc_flags_s;
    logic                     ready_s;
    logic                     accept_s;
    logic                     bad_s;
    logic                     load_s;

    logic                     valid_d, valid_q;
    logic [BIN_WIDTH-1:0]     bin_d, bin_q;
    oh_flags_t                flags_d, flags_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_d, err_cnt_q;

    onehot_enc_prio #(
        .ONEHOT_WIDTH (ONEHOT_WIDTH),
        .PRIO_MSB     (PRIO_MSB)
    ) u_enc (
        .onehot_i (onehot_i),
        .bin_o    (enc_bin_s),
        .flags_o  (enc_flags_s)
    );

    assign ready_s  = ~flush_i & (~valid_q | ready_i);
    assign accept_s = valid_i & ready_s;
    assign bad_s    = enc_flags_s.zero | enc_flags_s.multi;
    // A dropped beat is still consumed (and counted) but never reaches the register.
    assign load_s   = accept_s & ~(DROP_INVALID & bad_s);

    // Output register next state: flush wins, then load, then drain on ready.
    always_comb begin
        valid_d = valid_q;
        bin_d   = bin_q;
        flags_d = flags_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_s) begin
            valid_d = 1'b1;
            bin_d   = enc_bin_s;
            flags_d = enc_flags_s;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Error counter: a clear coinciding with a counted beat leaves a count of one.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr_i) begin
            err_cnt_d = (accept_s & bad_s) ? ERR_CNT_WIDTH'(1) : '0;
        end else if (accept_s && bad_s && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            bin_q     <= '0;
            flags_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            bin_q     <= bin_d;
            flags_q   <= flags_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ready_o   = ready_s;
    assign valid_o   = valid_q;
    assign bin_o     = bin_q;
    assign zero_o    = flags_q.zero;
    assign multi_o   = flags_q.multi;
    assign err_cnt_o = err_cnt_q;

endmodule
